clint_timer_array: RTL and testbench
====================================

// Module: clint_timer_array
// PURPOSE
//  Multi-hart CLINT-style timer/IPI block, successor of the single-hart MMIO timer. Sits behind the AXI-lite-to-memory bridge on the MMIO bus.
//  Holds one shared 64-bit mtime, plus a per-hart mtimecmp and msip.
//  Drives per-hart machine timer (mtip) and software (msip) interrupt lines.
//  Adds a programmable prescaler and byte-strobed access; request/response handshake allows back-pressure.
// PARAMETERS
//  ADDR_WIDTH  64  request address width; only addr[15:0] is decoded
//  NUM_HARTS   2   hart count, legal range 1..16
//  PRESCALE    1   clocks per mtime increment, >=1; 1 = increment every clock
// PORTS
//  clk          in   1           system clock
//  rstn         in   1           synchronous active-low reset
//  req_valid    in   1           request valid
//  req_ready    out  1           request accepted when req_valid&req_ready
//  req_we       in   1           1=write, 0=read
//  req_addr     in   ADDR_WIDTH  byte address, 8-byte aligned
//  req_wdata    in   64          write data
//  req_wstrb    in   8           byte enables for writes
//  resp_valid   out  1           response valid
//  resp_ready   in   1           response consumed when resp_valid&resp_ready
//  resp_rdata   out  64          read data; 0 for writes or errors
//  resp_err     out  1           unmapped or misaligned access
//  mtip         out  NUM_HARTS   timer interrupt per hart
//  msip         out  NUM_HARTS   software interrupt per hart
//  cosim_mtime  out  64          current mtime, for co-simulation
// BEHAVIOUR
//  Map, offsets on addr[15:0]:
//   msip[h]     0x0000+8*h  bit0 only; other bits read 0
//   mtimecmp[h] 0x4000+8*h
//   mtime       0xBFF8
//   Any other offset or addr[2:0]!=0 is an error: read returns 0, write has no effect, resp_err=1.
//  Reset (rstn=0 at a clk edge), from the next cycle:
//   mtime=0, mtimecmp[*]=64'hFFFF_FFFF_FFFF_FFFF, msip=0, mtip=0.
//   Prescaler count=0, FSM=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//   Reset mid-transaction drops any pending response.
//  FSM, one outstanding transaction:
//   IDLE: req_ready=1. On req_valid, decode and perform the access in that same edge:
//    writes commit, reads sample register contents. Go to RESP.
//   RESP: req_ready=0, resp_valid=1, rdata/err held stable. On resp_ready, go to IDLE.
//   Minimum round trip: accept at edge N, resp_valid high during cycle N+1.
//  Writes: byte lane i updated iff wstrb[i]. wstrb=0 is a legal no-op with resp_err=0.
//  Reads return the register value before any same-cycle tick.
//  mtime:
//   The prescaler counts 0..PRESCALE-1; a tick fires when it wraps.
//   On a tick, mtime+=1 modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
//   A write to mtime in the same cycle as a tick wins: the written bytes are kept, unwritten bytes take the incremented value.
//   Writing mtime does not reset the prescaler.
//  mtip[h] is registered: mtip[h] <= (mtime >= mtimecmp[h]), unsigned, sampled on current register values.
//   mtip therefore lags a mtime/mtimecmp change by 1 cycle.
//   It stays level-high until mtimecmp is raised or mtime wraps.
//  msip[h] drives directly from its register bit.
//  cosim_mtime = mtime register, combinational.
// TESTING
//  T1 reset: mtime=0, all mtip=0, read 0x4000 -> 64'hFFFF_FFFF_FFFF_FFFF, err=0.
//  T2 PRESCALE=4, idle 40 clocks after reset -> mtime=10; read 0xBFF8 returns 10.
//  T3 write mtimecmp[1]=20 with mtime=15 -> mtip[1] rises exactly when mtime=20 plus 1 cycle; mtip[0] stays 0.
//     Then write mtimecmp[1]=100 -> mtip[1] falls the next cycle.
//  T4 write 0xBFF8 with 64'hFFFF_FFFF_FFFF_FFFE, PRESCALE=1 -> mtime reads ...FFFF, then 0 on the following tick.
//     Also: wstrb=8'h0F write to mtime on a tick edge -> low 4 bytes = wdata, high 4 bytes = incremented value.
//  T5 write 0x0008 wdata=1 -> msip[1]=1. Read back -> 1.
//     Read 0x0009 -> err=1, rdata=0. Read 0x0000+8*NUM_HARTS -> err=1.
//  T6 hold resp_ready=0 for 5 cycles -> resp_valid, rdata, err stable, req_ready=0.
//     Assert rstn=0 mid-hold -> resp_valid=0 next cycle, with all state reset.

Source files
------------

// File: rtl/clint_timer_array.sv
// Multi-hart CLINT timer/IPI block: shared prescaled 64-bit mtime, per-hart mtimecmp/msip,
// byte-strobed MMIO access with a one-outstanding request/response handshake.
module clint_timer_array #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned NUM_HARTS  = 2,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_wdata,
  input  logic [7:0]            req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [63:0]           resp_rdata,
  output logic                  resp_err,
  output logic [NUM_HARTS-1:0]  mtip,
  output logic [NUM_HARTS-1:0]  msip,
  output logic [63:0]           cosim_mtime
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state;
  logic [63:0] mtime;
  logic [63:0] mtimecmp [NUM_HARTS];
  logic [31:0] presc_cnt;

  logic        tick;
  logic [63:0] mtime_inc;
  logic [15:0] offset;
  logic [3:0]  idx;
  logic        aligned;
  logic        hit_msip;
  logic        hit_cmp;
  logic        hit_mtime;
  logic        dec_err;
  logic [63:0] rd_val;
  logic [63:0] wmask;
  logic        accept;
  logic        do_write;
  logic        unused_addr_hi;

  if (ADDR_WIDTH > 16) begin : g_addr_hi
    assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:16];
  end else begin : g_no_addr_hi
    assign unused_addr_hi = 1'b0;
  end

  assign cosim_mtime = mtime;

  always_comb begin
    offset    = req_addr[15:0];
    idx       = offset[6:3];
    aligned   = (offset[2:0] == 3'd0);
    tick      = (presc_cnt == PRESCALE - 1);
    mtime_inc = tick ? mtime + 64'd1 : mtime;
    hit_msip  = 1'b0;
    hit_cmp   = 1'b0;
    rd_val    = '0;
    // Hart select by compare rather than array index keeps idx >= NUM_HARTS unmapped.
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (aligned && idx == 4'(h)) begin
        if (offset[15:7] == 9'h000) begin
          hit_msip = 1'b1;
          rd_val   = {63'd0, msip[h]};
        end
        if (offset[15:7] == 9'h080) begin
          hit_cmp = 1'b1;
          rd_val  = mtimecmp[h];
        end
      end
    end
    hit_mtime = (offset == 16'hBFF8);
    if (hit_mtime) rd_val = mtime;
    dec_err = !(hit_msip || hit_cmp || hit_mtime);
    for (int unsigned i = 0; i < 8; i++) wmask[8*i +: 8] = {8{req_wstrb[i]}};
    accept   = (state == IDLE) && req_valid;
    do_write = accept && req_we && !dec_err;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      presc_cnt  <= '0;
      mtime      <= '0;
      mtip       <= '0;
      msip       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 32'd1;
      // Unwritten mtime bytes still advance on a tick coinciding with the write.
      if (do_write && hit_mtime) mtime <= (mtime_inc & ~wmask) | (req_wdata & wmask);
      else                       mtime <= mtime_inc;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        mtip[h] <= (mtime >= mtimecmp[h]);
        if (do_write && hit_cmp && idx == 4'(h))
          mtimecmp[h] <= (mtimecmp[h] & ~wmask) | (req_wdata & wmask);
        if (do_write && hit_msip && idx == 4'(h) && req_wstrb[0])
          msip[h] <= req_wdata[0];
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= RESP;
            req_ready  <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= (req_we || dec_err) ? '0 : rd_val;
            resp_err   <= dec_err;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer_array.sv
// Directed self-checking bench for clint_timer_array: a PRESCALE=1 instance for most
// scenarios plus a PRESCALE=4 instance for prescaler timing.
module tb_clint_timer_array;

  logic        clk = 1'b0;
  logic        rstn;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [63:0] req_addr, req_wdata, resp_rdata, cosim_mtime;
  logic [7:0]  req_wstrb;
  logic [1:0]  mtip, msip;

  logic        p4_req_valid, p4_req_ready, p4_req_we, p4_resp_valid, p4_resp_ready, p4_resp_err;
  logic [63:0] p4_req_addr, p4_req_wdata, p4_resp_rdata, p4_cosim_mtime;
  logic [7:0]  p4_req_wstrb;
  logic [1:0]  p4_mtip, p4_msip;

  int vectors = 0;
  int miscompares = 0;

  clint_timer_array #(.ADDR_WIDTH(64), .NUM_HARTS(2), .PRESCALE(1)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mtip(mtip), .msip(msip), .cosim_mtime(cosim_mtime)
  );

  clint_timer_array #(.ADDR_WIDTH(64), .NUM_HARTS(2), .PRESCALE(4)) dut_p4 (
    .clk(clk), .rstn(rstn),
    .req_valid(p4_req_valid), .req_ready(p4_req_ready), .req_we(p4_req_we), .req_addr(p4_req_addr),
    .req_wdata(p4_req_wdata), .req_wstrb(p4_req_wstrb),
    .resp_valid(p4_resp_valid), .resp_ready(p4_resp_ready), .resp_rdata(p4_resp_rdata),
    .resp_err(p4_resp_err),
    .mtip(p4_mtip), .msip(p4_msip), .cosim_mtime(p4_cosim_mtime)
  );

  // One full transaction on the PRESCALE=1 instance; returns 1ns after the handshake edge.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [63:0] wd,
                     input logic [7:0] ws, output logic [63:0] rd, output logic er);
    int unsigned n;
    n = 0;
    while (!req_ready && n < 10) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_we = we; req_addr = {48'h0, addr}; req_wdata = wd; req_wstrb = ws;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    n = 0;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    vectors++;
    if (resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL txn_timeout addr=%h resp_valid=%b required 1", addr, resp_valid);
    end
    rd = resp_rdata; er = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    vectors++;
    if (cosim_mtime !== 64'd0 || mtip !== 2'b00 || msip !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_state mtime=%h mtip=%b msip=%b required 0/00/00", cosim_mtime, mtip, msip);
    end
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    vectors++;
    if (p4_cosim_mtime !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_p4_mtime got %h required 0", p4_cosim_mtime);
    end
  endtask

  task automatic test_prescale;
    repeat (40) @(posedge clk);
    #1;
    vectors++;
    if (p4_cosim_mtime !== 64'd10) begin
      miscompares++;
      $display("FAIL prescale_mtime got %0d required 10", p4_cosim_mtime);
    end
    p4_req_valid = 1'b1; p4_req_we = 1'b0; p4_req_addr = 64'hBFF8;
    @(posedge clk); #1;
    p4_req_valid = 1'b0;
    vectors++;
    if (p4_resp_valid !== 1'b1 || p4_resp_rdata !== 64'd10 || p4_resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL prescale_read valid=%b rdata=%0d err=%b required 1/10/0",
               p4_resp_valid, p4_resp_rdata, p4_resp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_readback;
    logic [63:0] rd;
    logic er;
    txn(1'b0, 16'h4000, 64'd0, 8'h00, rd, er);
    vectors++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || er !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mtimecmp0 rdata=%h err=%b required ffffffffffffffff/0", rd, er);
    end
  endtask

  task automatic test_mtip;
    logic [63:0] rd;
    logic er;
    bit seen20, seen21;
    seen20 = 0; seen21 = 0;
    txn(1'b1, 16'hBFF8, 64'd14, 8'hFF, rd, er);
    txn(1'b1, 16'h4008, 64'd20, 8'hFF, rd, er);
    for (int i = 0; i < 20 && !seen21; i++) begin
      if (cosim_mtime == 64'd20) begin
        seen20 = 1;
        vectors++;
        if (mtip[1] !== 1'b0) begin
          miscompares++;
          $display("FAIL mtip_early mtip1=%b at mtime=20 required 0", mtip[1]);
        end
      end
      if (cosim_mtime == 64'd21) begin
        seen21 = 1;
        vectors++;
        if (mtip !== 2'b10) begin
          miscompares++;
          $display("FAIL mtip_rise mtip=%b at mtime=21 required 10", mtip);
        end
      end
      if (!seen21) begin @(posedge clk); #1; end
    end
    vectors++;
    if (!(seen20 && seen21)) begin
      miscompares++;
      $display("FAIL mtip_window seen20=%0d seen21=%0d required 1/1", seen20, seen21);
    end
    txn(1'b1, 16'h4008, 64'd100, 8'hFF, rd, er);
    vectors++;
    if (mtip !== 2'b00 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL mtip_fall mtip=%b err=%b required 00/0", mtip, er);
    end
  endtask

  task automatic test_mtime_wrap;
    logic [63:0] rd;
    logic er;
    txn(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
    vectors++;
    if (cosim_mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL mtime_pre_wrap got %h required ffffffffffffffff", cosim_mtime);
    end
    txn(1'b0, 16'hBFF8, 64'd0, 8'h00, rd, er);
    vectors++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || er !== 1'b0) begin
      miscompares++;
      $display("FAIL mtime_read_before_tick rdata=%h err=%b required ffffffffffffffff/0", rd, er);
    end
    vectors++;
    if (cosim_mtime !== 64'd1) begin
      miscompares++;
      $display("FAIL mtime_wrapped got %h required 1", cosim_mtime);
    end
    txn(1'b1, 16'hBFF8, 64'h0000_0005_FFFF_FFFE, 8'hFF, rd, er);
    txn(1'b1, 16'hBFF8, 64'hAAAA_AAAA_1234_5678, 8'h0F, rd, er);
    vectors++;
    if (cosim_mtime !== 64'h0000_0006_1234_5679) begin
      miscompares++;
      $display("FAIL mtime_partial_tick got %h required 0000000612345679", cosim_mtime);
    end
    txn(1'b1, 16'h4000, 64'd5, 8'h00, rd, er);
    vectors++;
    if (er !== 1'b0 || rd !== 64'd0) begin
      miscompares++;
      $display("FAIL wstrb0_resp err=%b rdata=%h required 0/0", er, rd);
    end
    txn(1'b0, 16'h4000, 64'd0, 8'h00, rd, er);
    vectors++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL wstrb0_noop rdata=%h required ffffffffffffffff", rd);
    end
  endtask

  task automatic test_msip;
    logic [63:0] rd;
    logic er;
    txn(1'b1, 16'h0008, 64'd1, 8'hFF, rd, er);
    vectors++;
    if (msip !== 2'b10 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL msip1_set msip=%b err=%b required 10/0", msip, er);
    end
    txn(1'b0, 16'h0008, 64'd0, 8'h00, rd, er);
    vectors++;
    if (rd !== 64'd1 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL msip1_read rdata=%h err=%b required 1/0", rd, er);
    end
    txn(1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er);
    txn(1'b0, 16'h0000, 64'd0, 8'h00, rd, er);
    vectors++;
    if (rd !== 64'd1 || msip !== 2'b11) begin
      miscompares++;
      $display("FAIL msip0_bit0_only rdata=%h msip=%b required 1/11", rd, msip);
    end
    txn(1'b0, 16'h0009, 64'd0, 8'h00, rd, er);
    vectors++;
    if (rd !== 64'd0 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL misaligned_read rdata=%h err=%b required 0/1", rd, er);
    end
    txn(1'b0, 16'h0010, 64'd0, 8'h00, rd, er);
    vectors++;
    if (rd !== 64'd0 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL unmapped_hart_read rdata=%h err=%b required 0/1", rd, er);
    end
    txn(1'b1, 16'h400C, 64'd0, 8'hFF, rd, er);
    txn(1'b0, 16'h4008, 64'd0, 8'h00, rd, er);
    vectors++;
    if (rd !== 64'd100) begin
      miscompares++;
      $display("FAIL err_write_no_effect mtimecmp1=%0d required 100", rd);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] rd;
    logic er;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h4008;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'd100 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d valid=%b rdata=%0d err=%b ready=%b required 1/100/0/0",
                 c, resp_valid, resp_rdata, resp_err, req_ready);
      end
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    resp_ready = 1'b1;
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_midhold valid=%b ready=%b rdata=%h required 0/1/0",
               resp_valid, req_ready, resp_rdata);
    end
    vectors++;
    if (cosim_mtime !== 64'd0 || msip !== 2'b00 || mtip !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_midhold_state mtime=%h msip=%b mtip=%b required 0/00/00",
               cosim_mtime, msip, mtip);
    end
    txn(1'b0, 16'h4008, 64'd0, 8'h00, rd, er);
    vectors++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || er !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midhold_cmp rdata=%h err=%b required ffffffffffffffff/0", rd, er);
    end
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0; resp_ready = 1'b1;
    p4_req_valid = 1'b0; p4_req_we = 1'b0; p4_req_addr = '0; p4_req_wdata = '0; p4_req_wstrb = '0;
    p4_resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    test_reset;
    test_prescale;
    test_reset_readback;
    test_mtip;
    test_mtime_wrap;
    test_msip;
    test_backpressure;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
